// File: rtl/axis_spi_pkg.sv
// Shared definitions for the AXIS <-> SPI bridges: FSM encodings, synchronizer
// depth and SPI mode constants.
package axis_spi_pkg;

  localparam int SYNC_STAGES = 2;

  // Mode 0: sck idles low, data sampled on the rising edge, MSB first.
  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_CPHA      = 1'b0;
  localparam logic SPI_MSB_FIRST = 1'b1;

  typedef enum logic [0:0] {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with a selectable reset level, so idle-high
// inputs such as chip selects come out of reset inactive.
module cdc_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= {STAGES{RST_VAL}};
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], d};
    end
  end

  assign q = sync_sr[STAGES-1];

endmodule

// File: rtl/axis_spi_slave_bridge.sv
// SPI mode-0 peripheral oversampled in the clk domain; received words leave on
// axis_o_*, transmitted words are taken from axis_i_*.
module axis_spi_slave_bridge
  import axis_spi_pkg::*;
#(
  parameter int                      AXIS_BYTES = 1,
  parameter logic [AXIS_BYTES*8-1:0] FILL       = {AXIS_BYTES{8'hFF}}
) (
  input  logic                    clk,
  input  logic                    aresetn,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic [AXIS_BYTES*8-1:0] axis_o_tdata,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  output logic                    overflow,
  output logic                    underrun,
  output logic [0:0]              dbg_state
);

  localparam int             W    = AXIS_BYTES * 8;
  localparam int             CW   = $clog2(W);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  logic          sck_s, cs_s, mosi_s;
  logic          sck_q, cs_q;
  logic          lead_s, lead_q;
  logic          rise, fall, sel, desel;
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [W-2:0]  rx_sr;
  logic [W-2:0]  tx_sr;
  logic          load_pend;
  logic          word_done;
  logic          load_now;
  logic [W-1:0]  rx_word;
  logic [W-1:0]  load_word;

  // Equal depth on all three pins keeps mosi aligned with the sck strobe.
  cdc_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(aresetn), .d(sck), .q(sck_s)
  );
  cdc_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(aresetn), .d(cs_n), .q(cs_s)
  );
  cdc_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(aresetn), .d(mosi), .q(mosi_s)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sck_q <= 1'b0;
      cs_q  <= 1'b1;
    end else begin
      sck_q <= sck_s;
      cs_q  <= cs_s;
    end
  end

  assign lead_s = sck_s ^ SPI_CPOL;
  assign lead_q = sck_q ^ SPI_CPOL;
  assign rise   = lead_s & ~lead_q;
  assign fall   = ~lead_s & lead_q;
  assign sel    = ~cs_s & cs_q;
  assign desel  = cs_s & ~cs_q;

  assign rx_word   = {rx_sr, mosi_s};
  assign load_word = axis_i_tvalid ? axis_i_tdata : FILL;
  assign word_done = (state == ST_ACTIVE) && rise && !desel && (cnt == LAST);
  assign load_now  = !desel &&
                     (((state == ST_IDLE) && sel) ||
                      ((state == ST_ACTIVE) && fall && load_pend));

  // Handshakes: a beat transfers in any cycle where tvalid and tready are both
  // high; axis_i_tready is only raised in the cycle the tx word is sampled.
  assign axis_i_tready = load_now && axis_i_tvalid;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      load_pend <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (desel) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        rx_sr     <= '0;
        load_pend <= 1'b0;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (sel) begin
          state     <= ST_ACTIVE;
          cnt       <= '0;
          load_pend <= 1'b0;
          tx_sr     <= load_word[W-2:0];
          miso      <= load_word[W-1];
          miso_oe   <= 1'b1;
          underrun  <= !axis_i_tvalid;
        end
      end else begin
        if (rise) begin
          rx_sr <= rx_word[W-2:0];
          if (cnt == LAST) begin
            cnt       <= '0;
            load_pend <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A fall right after a completed word starts the next tx word.
        if (fall) begin
          if (load_pend) begin
            tx_sr     <= load_word[W-2:0];
            miso      <= load_word[W-1];
            underrun  <= !axis_i_tvalid;
            load_pend <= 1'b0;
          end else begin
            miso  <= tx_sr[W-2];
            tx_sr <= {tx_sr[W-3:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      axis_o_tvalid <= 1'b0;
      axis_o_tdata  <= '0;
      overflow      <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (word_done) begin
        if (axis_o_tvalid && !axis_o_tready) begin
          overflow <= 1'b1;
        end else begin
          axis_o_tdata  <= rx_word;
          axis_o_tvalid <= 1'b1;
        end
      end else if (axis_o_tvalid && axis_o_tready) begin
        axis_o_tvalid <= 1'b0;
      end
    end
  end

endmodule
